// File: rtl/stack_op_sequencer.sv
// Operation sequencer for an external data stack. Accepts one stack operation at a
// time, checks occupancy, then drives the single-cycle stack strobes and reports completion.
module stack_op_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic [1:0]       err_code,
  output logic             ds_push,
  output logic             ds_pop,
  output logic             ds_data_write,
  output logic             ds_sr1_overwrite,
  output logic [WIDTH-1:0] ds_sr0_in,
  output logic [WIDTH-1:0] ds_sr1_in,
  input  logic [WIDTH-1:0] ds_sr0_out,
  input  logic [WIDTH-1:0] ds_sr1_out,
  input  logic [15:0]      ds_size
);

  localparam logic [2:0] OpNop  = 3'd0;
  localparam logic [2:0] OpPush = 3'd1;
  localparam logic [2:0] OpPop  = 3'd2;
  localparam logic [2:0] OpDup  = 3'd3;
  localparam logic [2:0] OpSwap = 3'd4;
  localparam logic [2:0] OpDrop = 3'd5;
  localparam logic [2:0] OpOver = 3'd6;
  localparam logic [2:0] OpPeek = 3'd7;

  localparam logic [15:0] DepthW = 16'(DEPTH);

  localparam logic [1:0] ErrNone      = 2'd0;
  localparam logic [1:0] ErrUnderflow = 2'd1;
  localparam logic [1:0] ErrOverflow  = 2'd2;

  typedef enum logic [1:0] {StIdle, StExec1, StExec2, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] sr0_q, sr0_d;
  logic [WIDTH-1:0] sr1_q, sr1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             push_c, pop_c, write_c, ovw_c, done_c, ready_c;
  logic [WIDTH-1:0] sr0_in_c, sr1_in_c;
  logic             need_one, need_two, grows, underflow, overflow;

  // Occupancy requirements of the latched operation.
  always_comb begin
    need_one  = (op_q == OpPop) || (op_q == OpDrop) || (op_q == OpPeek) || (op_q == OpDup);
    need_two  = (op_q == OpSwap) || (op_q == OpOver);
    grows     = (op_q == OpPush) || (op_q == OpDup) || (op_q == OpOver);
    underflow = (need_one && (ds_size < 16'd1)) || (need_two && (ds_size < 16'd2));
    overflow  = grows && (ds_size >= DepthW);
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    sr0_d      = sr0_q;
    sr1_d      = sr1_q;
    result_d   = result_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    write_c    = 1'b0;
    ovw_c      = 1'b0;
    done_c     = 1'b0;
    ready_c    = 1'b0;
    sr0_in_c   = '0;
    sr1_in_c   = '0;

    unique case (state_q)
      StIdle: begin
        ready_c = 1'b1;
        if (op_valid) begin
          op_d       = op_code;
          data_d     = op_data;
          err_d      = 1'b0;
          err_code_d = ErrNone;
          state_d    = StExec1;
        end
      end

      StExec1: begin
        result_d = '0;
        state_d  = StDone;
        if (underflow || overflow) begin
          // Underflow wins when both apply.
          err_d      = 1'b1;
          err_code_d = underflow ? ErrUnderflow : ErrOverflow;
        end else begin
          unique case (op_q)
            OpNop: ;
            OpPush: begin
              push_c   = 1'b1;
              write_c  = 1'b1;
              sr0_in_c = data_q;
            end
            OpPop: begin
              result_d = ds_sr0_out;
              pop_c    = 1'b1;
            end
            OpDrop: pop_c = 1'b1;
            OpPeek: result_d = ds_sr0_out;
            OpDup, OpSwap, OpOver: begin
              sr0_d   = ds_sr0_out;
              sr1_d   = ds_sr1_out;
              state_d = StExec2;
            end
            default: ;
          endcase
        end
      end

      StExec2: begin
        result_d = '0;
        state_d  = StDone;
        case (op_q)
          OpDup: begin
            push_c   = 1'b1;
            write_c  = 1'b1;
            sr0_in_c = sr0_q;
          end
          OpOver: begin
            push_c   = 1'b1;
            write_c  = 1'b1;
            sr0_in_c = sr1_q;
          end
          OpSwap: begin
            write_c  = 1'b1;
            ovw_c    = 1'b1;
            sr0_in_c = sr1_q;
            sr1_in_c = sr0_q;
          end
          default: ;
        endcase
      end

      StDone: begin
        done_c  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpNop;
      data_q     <= '0;
      sr0_q      <= '0;
      sr1_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      sr0_q      <= sr0_d;
      sr1_q      <= sr1_d;
      result_q   <= result_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Reset masks the strobes immediately so an aborted operation never touches the stack.
  assign op_ready         = ready_c;
  assign done             = done_c && !reset;
  assign result           = result_q;
  assign error            = done && err_q;
  assign err_code         = done ? err_code_q : ErrNone;
  assign ds_push          = push_c && !reset;
  assign ds_pop           = pop_c && !reset;
  assign ds_data_write    = write_c && !reset;
  assign ds_sr1_overwrite = ovw_c && !reset;
  assign ds_sr0_in        = reset ? '0 : sr0_in_c;
  assign ds_sr1_in        = reset ? '0 : sr1_in_c;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Scoreboard bench for stack_op_sequencer: directed operations push expected completions,
// a negedge monitor accumulates stack strobes per operation and checks each done pulse.
module tb_stack_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [15:0] op_data;
  logic        op_ready, done, error;
  logic [15:0] result;
  logic [1:0]  err_code;
  logic        ds_push, ds_pop, ds_data_write, ds_sr1_overwrite;
  logic [15:0] ds_sr0_in, ds_sr1_in, ds_sr0_out, ds_sr1_out, ds_size;

  stack_op_sequencer #(.WIDTH(16), .DEPTH(128)) dut (
    .clk             (clk),
    .reset           (reset),
    .op_valid        (op_valid),
    .op_code         (op_code),
    .op_data         (op_data),
    .op_ready        (op_ready),
    .done            (done),
    .result          (result),
    .error           (error),
    .err_code        (err_code),
    .ds_push         (ds_push),
    .ds_pop          (ds_pop),
    .ds_data_write   (ds_data_write),
    .ds_sr1_overwrite(ds_sr1_overwrite),
    .ds_sr0_in       (ds_sr0_in),
    .ds_sr1_in       (ds_sr1_in),
    .ds_sr0_out      (ds_sr0_out),
    .ds_sr1_out      (ds_sr1_out),
    .ds_size         (ds_size)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic [1:0]  code;
    int          lat;
    int          npush, npop, nwr, novw;
    logic [15:0] s0, s1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   b2b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] res, input logic err, input logic [1:0] code,
                              input int lat, input int np, input int npo, input int nw,
                              input int no, input logic [15:0] s0, input logic [15:0] s1);
    exp_t e;
    e.res = res; e.err = err; e.code = code; e.lat = lat;
    e.npush = np; e.npop = npo; e.nwr = nw; e.novw = no; e.s0 = s0; e.s1 = s1;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: strobe accumulation, done checking against the scoreboard, accept spacing.
  initial begin
    int   acc_edge, prev_acc;
    int   np, npo, nw, no;
    bit   both, have_prev;
    logic [15:0] s0, s1;
    exp_t e;
    acc_edge = 0; prev_acc = 0; have_prev = 0;
    np = 0; npo = 0; nw = 0; no = 0; both = 0; s0 = '0; s1 = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        np = 0; npo = 0; nw = 0; no = 0; both = 0; have_prev = 0;
      end else begin
        if (ds_push) np++;
        if (ds_pop) npo++;
        if (ds_push && ds_pop) both = 1;
        if (ds_data_write) begin nw++; s0 = ds_sr0_in; end
        if (ds_sr1_overwrite) begin no++; s1 = ds_sr1_in; end
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("error", 32'(error), 32'(e.err));
            chk("err_code", 32'(err_code), 32'(e.code));
            chk("latency", 32'(cyc + 1 - acc_edge), 32'(e.lat));
            chk("n_push", 32'(np), 32'(e.npush));
            chk("n_pop", 32'(npo), 32'(e.npop));
            chk("n_write", 32'(nw), 32'(e.nwr));
            chk("n_sr1_ovw", 32'(no), 32'(e.novw));
            chk("push_and_pop", 32'(both), 32'd0);
            if (e.nwr > 0) chk("sr0_in", 32'(s0), 32'(e.s0));
            if (e.novw > 0) chk("sr1_in", 32'(s1), 32'(e.s1));
          end
        end else begin
          if (error !== 1'b0) chk("error_idle", 32'(error), 32'd0);
          if (err_code !== 2'd0) chk("err_code_idle", 32'(err_code), 32'd0);
        end
        if (op_valid && op_ready) begin
          prev_acc = acc_edge;
          acc_edge = cyc + 1;
          if (b2b && have_prev) chk("accept_gap", 32'(acc_edge - prev_acc), 32'd3);
          have_prev = 1;
          np = 0; npo = 0; nw = 0; no = 0; both = 0;
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) chk("ready_timeout", 32'(op_ready), 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] data, input logic [15:0] size,
                       input logic [15:0] s0, input logic [15:0] s1, input exp_t e);
    wait_ready();
    @(posedge clk);
    #1;
    op_code = op; op_data = data; ds_size = size; ds_sr0_out = s0; ds_sr1_out = s1;
    op_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code = 3'd0;
    op_data = 16'hFFFF;  // ignored once accepted
    repeat (5) @(posedge clk);
    #1;
    chk("drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = '0; op_data = '0;
    ds_sr0_out = '0; ds_sr1_out = '0; ds_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_strobes", 32'({ds_push, ds_pop, ds_data_write, ds_sr1_overwrite}), 32'd0);
    chk("rst_data", 32'({ds_sr0_in, ds_sr1_in}), 32'd0);
    #1;
    reset = 1'b0;

    issue(3'd1, 16'h0005, 16'd0, 16'h0, 16'h0, mk(16'h0, 0, 0, 2, 1, 0, 1, 0, 16'h0005, 0));
    issue(3'd2, 16'h0, 16'd3, 16'h00AA, 16'h0, mk(16'h00AA, 0, 0, 2, 0, 1, 0, 0, 0, 0));
    issue(3'd4, 16'h0, 16'd2, 16'h0002, 16'h0063,
          mk(16'h0, 0, 0, 3, 0, 0, 1, 1, 16'h0063, 16'h0002));
    issue(3'd2, 16'h0, 16'd0, 16'h1111, 16'h0, mk(16'h0, 1, 1, 2, 0, 0, 0, 0, 0, 0));
    issue(3'd1, 16'h0042, 16'd128, 16'h0, 16'h0, mk(16'h0, 1, 2, 2, 0, 0, 0, 0, 0, 0));
    issue(3'd6, 16'h0, 16'd1, 16'h0001, 16'h0, mk(16'h0, 1, 1, 2, 0, 0, 0, 0, 0, 0));
    issue(3'd6, 16'h0, 16'd128, 16'h0001, 16'h0002, mk(16'h0, 1, 2, 2, 0, 0, 0, 0, 0, 0));
    issue(3'd4, 16'h0, 16'd1, 16'h0001, 16'h0002, mk(16'h0, 1, 1, 2, 0, 0, 0, 0, 0, 0));
    issue(3'd7, 16'h0, 16'd1, 16'h1234, 16'h0, mk(16'h1234, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    chk("result_hold", 32'(result), 32'h1234);
    issue(3'd3, 16'h0, 16'd5, 16'h7777, 16'h0, mk(16'h0, 0, 0, 3, 1, 0, 1, 0, 16'h7777, 0));
    issue(3'd6, 16'h0, 16'd2, 16'h0001, 16'hBEEF,
          mk(16'h0, 0, 0, 3, 1, 0, 1, 0, 16'hBEEF, 0));
    issue(3'd5, 16'h0, 16'd1, 16'h0009, 16'h0, mk(16'h0, 0, 0, 2, 0, 1, 0, 0, 0, 0));
    issue(3'd0, 16'h0, 16'd0, 16'h0, 16'h0, mk(16'h0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    issue(3'd3, 16'h0, 16'd0, 16'h0, 16'h0, mk(16'h0, 1, 1, 2, 0, 0, 0, 0, 0, 0));

    // DUP aborted by reset while in EXEC2.
    wait_ready();
    @(posedge clk);
    #1;
    op_code = 3'd3; ds_size = 16'd4; ds_sr0_out = 16'h5555; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_push", 32'(ds_push), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(op_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_drained", 32'(sb.size()), 32'd0);

    // 20 back-to-back pushes with op_valid held high.
    wait_ready();
    @(posedge clk);
    #1;
    b2b = 1'b1;
    op_valid = 1'b1;
    op_code = 3'd1;
    for (int i = 0; i < 20; i++) begin
      op_data = 16'(16'h0100 + i);
      ds_size = 16'(i);
      sb.push_back(mk(16'h0, 0, 0, 2, 1, 0, 1, 0, 16'(16'h0100 + i), 0));
      wait_ready();
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_drained", 32'(sb.size()), 32'd0);
    b2b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
